// File: rtl/stack_cpu_mc_pkg.sv
// stack_cpu_mc_pkg: shared defaults, opcodes, FSM states and error codes for the multi-cycle stack CPU
package stack_cpu_mc_pkg;
   localparam int DATA_WIDTH_DEF  = 16;
   localparam int STACK_DEPTH_DEF = 8;
   localparam int INSTR_WIDTH_DEF = 16;
   localparam int PC_WIDTH_DEF    = 8;
   localparam int IMM_WIDTH_DEF   = 11;
   localparam bit SATURATE_DEF    = 1'b0;

   typedef enum logic [4:0] {
      OP_PUSH   = 5'h00,
      OP_ADD    = 5'h01,
      OP_SUB    = 5'h02,
      OP_MUL    = 5'h03,
      OP_DIV    = 5'h04,
      OP_MOD    = 5'h05,
      OP_AND    = 5'h06,
      OP_OR     = 5'h07,
      OP_INVERT = 5'h08,
      OP_DUP    = 5'h09,
      OP_DROP   = 5'h0a,
      OP_SWAP   = 5'h0b,
      OP_NEG    = 5'h0c,
      OP_JZ     = 5'h0d,
      OP_JMP    = 5'h0e,
      OP_HALT   = 5'h1f
   } opcode_t;

   typedef enum logic [2:0] {S_FETCH, S_EXEC, S_DIV, S_WB, S_HALTED, S_ERRORED} state_t;

   typedef enum logic [2:0] {E_NONE, E_UNDERFLOW, E_OVERFLOW, E_DIV0, E_ILLEGAL} err_t;

   function automatic logic is_legal(input logic [4:0] op);
      return op <= OP_JMP || op == OP_HALT;
   endfunction

   // stack entries an opcode consumes before it can execute
   function automatic logic [1:0] need_depth(input logic [4:0] op);
      return (op == OP_PUSH || op == OP_JMP || op == OP_HALT) ? 2'd0 :
             (op == OP_INVERT || op == OP_DUP || op == OP_DROP || op == OP_NEG || op == OP_JZ) ? 2'd1 : 2'd2;
   endfunction
endpackage

// File: rtl/stack_cpu_mc_divider.sv
// stack_divider: iterative restoring signed divider, one quotient bit per cycle
module stack_divider import stack_cpu_mc_pkg::*; #(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic signed [DATA_WIDTH-1:0] dividend,
   input  logic signed [DATA_WIDTH-1:0] divisor,
   output logic signed [DATA_WIDTH-1:0] quotient,
   output logic signed [DATA_WIDTH-1:0] remainder,
   output logic                         busy,
   output logic                         done,
   output logic                         ovf
);
   localparam int CW = $clog2(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] q, d, r;
   logic [DATA_WIDTH:0]   r_sh, diff;
   logic [CW-1:0]         cnt;
   logic                  q_neg, r_neg;

   assign r_sh      = {r, q[DATA_WIDTH-1]};
   assign diff      = r_sh - {1'b0, d};
   assign done      = busy && cnt == CW'(DATA_WIDTH - 1);
   assign quotient  = q_neg ? -q : q;
   assign remainder = r_neg ? -r : r;
   // a positive quotient with the MSB set only arises from signed-min / -1
   assign ovf       = !q_neg && q[DATA_WIDTH-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy  <= 1'b0;
         cnt   <= '0;
         q     <= '0;
         d     <= '0;
         r     <= '0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
      end else if (start) begin
         busy  <= 1'b1;
         cnt   <= '0;
         r     <= '0;
         q     <= dividend[DATA_WIDTH-1] ? -dividend : dividend;
         d     <= divisor[DATA_WIDTH-1] ? -divisor : divisor;
         q_neg <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
         r_neg <= dividend[DATA_WIDTH-1];
      end else if (busy) begin
         q     <= {q[DATA_WIDTH-2:0], !diff[DATA_WIDTH]};
         r     <= diff[DATA_WIDTH] ? r_sh[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
         cnt   <= cnt + CW'(1);
         busy  <= !done;
      end
   end
endmodule

// File: rtl/stack_cpu_mc.sv
// stack_cpu_mc: multi-cycle stack CPU with iterative divider, optional saturation and encoded errors
module stack_cpu_mc import stack_cpu_mc_pkg::*; #(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int STACK_DEPTH = STACK_DEPTH_DEF,
   parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
   parameter int PC_WIDTH    = PC_WIDTH_DEF,
   parameter int IMM_WIDTH   = IMM_WIDTH_DEF,
   parameter bit SATURATE    = SATURATE_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [INSTR_WIDTH-1:0]       instruction,
   output logic [PC_WIDTH-1:0]          pc,
   output logic signed [DATA_WIDTH-1:0] result,
   output logic                         valid_result,
   output logic                         error,
   output logic [2:0]                   err_code,
   output logic                         halt,
   output logic                         busy
);
   localparam int AW = $clog2(STACK_DEPTH);
   localparam int SW = AW + 1;
   localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   state_t                       state, state_nx;
   err_t                         err_nx;
   logic [INSTR_WIDTH-1:0]       ir;
   logic [4:0]                   op;
   logic [IMM_WIDTH-1:0]         imm;
   logic [PC_WIDTH-1:0]          pc_nx, tgt;
   logic [SW-1:0]                sp, sp_nx;
   logic signed [DATA_WIDTH-1:0] stk [STACK_DEPTH];
   logic signed [DATA_WIDTH-1:0] tos, nos, imm_sx, alu, res_nx, wd_a, wd_b, quo, rem, dv;
   logic [DATA_WIDTH:0]          sum, dif, ngt;
   logic [2*DATA_WIDTH-1:0]      prod;
   logic [AW-1:0]                i_top, i_nos, i_push, wa_a, wa_b;
   logic                         we_a, we_b, vld_nx, start, div_done, div_ovf, mul_fit;

   assign op     = ir[INSTR_WIDTH-1 -: 5];
   assign imm    = ir[IMM_WIDTH-1:0];
   assign imm_sx = DATA_WIDTH'($signed(imm));
   assign tgt    = PC_WIDTH'(imm);
   assign i_top  = AW'(sp - SW'(1));
   assign i_nos  = AW'(sp - SW'(2));
   assign i_push = AW'(sp);
   assign tos    = stk[i_top];
   assign nos    = stk[i_nos];

   // one extra bit exposes signed overflow as a mismatch of the top two bits
   assign sum     = {nos[DATA_WIDTH-1], nos} + {tos[DATA_WIDTH-1], tos};
   assign dif     = {nos[DATA_WIDTH-1], nos} - {tos[DATA_WIDTH-1], tos};
   assign ngt     = '0 - {tos[DATA_WIDTH-1], tos};
   assign prod    = {{DATA_WIDTH{nos[DATA_WIDTH-1]}}, nos} * {{DATA_WIDTH{tos[DATA_WIDTH-1]}}, tos};
   assign mul_fit = &prod[2*DATA_WIDTH-1:DATA_WIDTH-1] || ~|prod[2*DATA_WIDTH-1:DATA_WIDTH-1];

   function automatic logic [DATA_WIDTH-1:0] clamp(input logic [DATA_WIDTH:0] v);
      return (SATURATE && v[DATA_WIDTH] != v[DATA_WIDTH-1]) ? (v[DATA_WIDTH] ? SMIN : SMAX) : v[DATA_WIDTH-1:0];
   endfunction

   always_comb begin
      alu = op == OP_ADD    ? clamp(sum) :
            op == OP_SUB    ? clamp(dif) :
            op == OP_MUL    ? ((SATURATE && !mul_fit) ? (prod[2*DATA_WIDTH-1] ? SMIN : SMAX) : prod[DATA_WIDTH-1:0]) :
            op == OP_AND    ? nos & tos :
            op == OP_OR     ? nos | tos :
            op == OP_INVERT ? ~tos : clamp(ngt);
      err_nx = !is_legal(op) ? E_ILLEGAL :
               sp < SW'(need_depth(op)) ? E_UNDERFLOW :
               ((op == OP_PUSH || op == OP_DUP) && sp == SW'(STACK_DEPTH)) ? E_OVERFLOW :
               ((op == OP_DIV || op == OP_MOD) && tos == '0) ? E_DIV0 : E_NONE;
      dv = op == OP_MOD ? rem : (SATURATE && div_ovf) ? SMAX : quo;
   end

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      sp_nx    = sp;
      res_nx   = result;
      vld_nx   = 1'b0;
      we_a     = 1'b0;
      wa_a     = i_top;
      wd_a     = alu;
      we_b     = 1'b0;
      wa_b     = i_nos;
      wd_b     = tos;
      start    = 1'b0;
      case (state)
         S_FETCH: state_nx = S_EXEC;
         S_EXEC: begin
            state_nx = S_FETCH;
            pc_nx    = pc + PC_WIDTH'(1);
            if (err_nx != E_NONE) begin
               state_nx = S_ERRORED;
               pc_nx    = pc;
            end else begin
               case (op)
                  OP_PUSH, OP_DUP: begin
                     we_a   = 1'b1;
                     wa_a   = i_push;
                     wd_a   = op == OP_PUSH ? imm_sx : tos;
                     sp_nx  = sp + SW'(1);
                     res_nx = wd_a;
                     vld_nx = 1'b1;
                  end
                  OP_DROP, OP_JZ: begin
                     sp_nx  = sp - SW'(1);
                     res_nx = sp > SW'(1) ? nos : result;
                     vld_nx = sp > SW'(1);
                     if (op == OP_JZ && tos == '0) pc_nx = tgt;
                  end
                  OP_JMP: pc_nx = tgt;
                  OP_SWAP: begin
                     we_a   = 1'b1;
                     wd_a   = nos;
                     we_b   = 1'b1;
                     res_nx = nos;
                     vld_nx = 1'b1;
                  end
                  OP_DIV, OP_MOD: begin
                     start    = 1'b1;
                     sp_nx    = sp - SW'(2);
                     pc_nx    = pc;
                     state_nx = S_DIV;
                  end
                  OP_HALT: begin
                     pc_nx    = pc;
                     state_nx = S_HALTED;
                  end
                  OP_INVERT, OP_NEG: begin
                     we_a   = 1'b1;
                     res_nx = alu;
                     vld_nx = 1'b1;
                  end
                  default: begin
                     we_a   = 1'b1;
                     wa_a   = i_nos;
                     sp_nx  = sp - SW'(1);
                     res_nx = alu;
                     vld_nx = 1'b1;
                  end
               endcase
            end
         end
         S_DIV: state_nx = div_done ? S_WB : S_DIV;
         S_WB: begin
            we_a     = 1'b1;
            wa_a     = i_push;
            wd_a     = dv;
            sp_nx    = sp + SW'(1);
            res_nx   = dv;
            vld_nx   = 1'b1;
            pc_nx    = pc + PC_WIDTH'(1);
            state_nx = S_FETCH;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_FETCH;
         ir           <= '0;
         pc           <= '0;
         sp           <= '0;
         result       <= '0;
         valid_result <= 1'b0;
         error        <= 1'b0;
         err_code     <= '0;
         halt         <= 1'b0;
      end else begin
         state        <= state_nx;
         pc           <= pc_nx;
         sp           <= sp_nx;
         result       <= res_nx;
         valid_result <= vld_nx;
         error        <= state_nx == S_ERRORED;
         halt         <= state_nx == S_HALTED;
         if (state == S_FETCH) ir <= instruction;
         if (state == S_EXEC && state_nx == S_ERRORED) err_code <= err_nx;
      end
   end

   // stack contents need no reset: sp alone defines which entries are live
   always_ff @(posedge clk) begin
      if (we_a) stk[wa_a] <= wd_a;
      if (we_b) stk[wa_b] <= wd_b;
   end

   stack_divider #(.DATA_WIDTH(DATA_WIDTH)) u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dividend  (nos),
      .divisor   (tos),
      .quotient  (quo),
      .remainder (rem),
      .busy      (busy),
      .done      (div_done),
      .ovf       (div_ovf)
   );
endmodule
